// File: rtl/pc_seq_ctrl_if.sv
// Fetch handshake and shared-adder bus between the next-PC sequencer and its neighbours.
// master: the sequencer; slave: fetch port plus external full_adder_30.
interface pc_seq_ctrl_if #(
  parameter int unsigned PC_W = 30
);
  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic            fetch_ready;
  logic [PC_W-1:0] adder_a;
  logic [PC_W-1:0] adder_b;
  logic [PC_W-1:0] adder_sum;

  modport master (
    output pc,
    output pc_valid,
    input  fetch_ready,
    output adder_a,
    output adder_b,
    input  adder_sum
  );

  modport slave (
    input  pc,
    input  pc_valid,
    output fetch_ready,
    input  adder_a,
    input  adder_b,
    output adder_sum
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: owns the PC and time-shares one external adder for increment/branch/jump.
// Optional macro PC_WRAP_DET_EN adds a sticky pc_wrap output flagging address wrap-around.
module pc_seq_ctrl #(
  parameter int unsigned     PC_W     = 30,
  parameter int unsigned     IMM_W    = 16,
  parameter int unsigned     JMP_W    = 26,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h00400000)
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_seq_ctrl_if.master    bus,
  input  logic             stall,
  input  logic             branch_req,
  input  logic             branch_taken,
  input  logic [IMM_W-1:0] br_imm,
  input  logic             jump_req,
  input  logic [JMP_W-1:0] jump_target,
  output logic             busy
`ifdef PC_WRAP_DET_EN
  ,output logic            pc_wrap
`endif
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BRANCH = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [PC_W-1:0]  pc_q, pc_next;
  logic [PC_W-1:0]  npc_q, npc_next;
  logic [IMM_W-1:0] imm_q, imm_next;
  logic             pc_valid_q;
  logic             busy_q;
  logic             consume;
  logic [PC_W-1:0]  op_a, op_b;
  logic [PC_W-1:0]  imm_sext;

  assign consume  = pc_valid_q & bus.fetch_ready & ~stall;
  assign imm_sext = {{(PC_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      npc_q      <= '0;
      imm_q      <= '0;
      pc_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_next;
      pc_q       <= pc_next;
      npc_q      <= npc_next;
      imm_q      <= imm_next;
      pc_valid_q <= (state_next == RUN);
      busy_q     <= (state_next == BRANCH);
    end
  end

  // Branch resolves in two adder passes: pc+1 into npc, then npc+sext(imm) into pc.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    npc_next   = npc_q;
    imm_next   = imm_q;
    op_a       = pc_q;
    op_b       = PC_W'(1);
    case (state)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (consume) begin
          if (jump_req) begin
            pc_next = {bus.adder_sum[PC_W-1:JMP_W], jump_target};
          end else if (branch_req && branch_taken) begin
            npc_next   = bus.adder_sum;
            imm_next   = br_imm;
            state_next = BRANCH;
          end else begin
            pc_next = bus.adder_sum;
          end
        end
      end
      BRANCH: begin
        op_a       = npc_q;
        op_b       = imm_sext;
        pc_next    = bus.adder_sum;
        state_next = RUN;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign bus.adder_a  = op_a;
  assign bus.adder_b  = op_b;
  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign busy         = busy_q;

`ifdef PC_WRAP_DET_EN
  logic sum_used;
  logic wrap_hit;
  logic wrap_q;

  assign sum_used = (state == BRANCH) | ((state == RUN) & consume);

  // Positive B wraps on carry-out (A msb set, sum msb clear); negative B
  // underflows past 0 on missing carry (A msb clear, sum msb set).
  always_comb begin
    wrap_hit = 1'b0;
    if (sum_used) begin
      if (op_b[PC_W-1])
        wrap_hit = ~op_a[PC_W-1] & bus.adder_sum[PC_W-1];
      else
        wrap_hit = op_a[PC_W-1] & ~bus.adder_sum[PC_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wrap_q <= 1'b0;
    else if (wrap_hit)
      wrap_q <= 1'b1;
  end

  assign pc_wrap = wrap_q;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed self-checking bench for pc_seq_ctrl with a behavioural model of the shared adder.
// Define PC_WRAP_DET_EN for both bench and RTL to exercise the wrap flag.
module tb_pc_seq_ctrl;

  localparam int unsigned PC_W  = 30;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned JMP_W = 26;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             branch_req;
  logic             branch_taken;
  logic [IMM_W-1:0] br_imm;
  logic             jump_req;
  logic [JMP_W-1:0] jump_target;
  logic             busy;
`ifdef PC_WRAP_DET_EN
  logic             pc_wrap;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  pc_seq_ctrl_if #(.PC_W(PC_W)) bus ();

  assign bus.adder_sum = bus.adder_a + bus.adder_b;

  pc_seq_ctrl #(
    .PC_W    (PC_W),
    .IMM_W   (IMM_W),
    .JMP_W   (JMP_W),
    .RESET_PC(30'h00400000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .stall       (stall),
    .branch_req  (branch_req),
    .branch_taken(branch_taken),
    .br_imm      (br_imm),
    .jump_req    (jump_req),
    .jump_target (jump_target),
    .busy        (busy)
`ifdef PC_WRAP_DET_EN
    ,.pc_wrap    (pc_wrap)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single jump from RUN; upper PC bits come from pc+1, which stay 0 in this bench's range.
  task automatic jump_to(input logic [JMP_W-1:0] tgt);
    jump_req    = 1'b1;
    jump_target = tgt;
    step();
    jump_req    = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    stall        = 1'b0;
    branch_req   = 1'b0;
    branch_taken = 1'b0;
    br_imm       = '0;
    jump_req     = 1'b0;
    jump_target  = '0;
    bus.fetch_ready = 1'b1;

    // Reset and boot sequence
    @(negedge clk);
    @(negedge clk);
    check("rst_pc",       32'(bus.pc),       32'h00400000);
    check("rst_valid",    32'(bus.pc_valid), 32'h0);
    check("rst_busy",     32'(busy),         32'h0);
    check("rst_adder_b",  32'(bus.adder_b),  32'h1);
`ifdef PC_WRAP_DET_EN
    check("rst_wrap",     32'(pc_wrap),      32'h0);
`endif
    rst_n = 1'b1;
    check("boot_valid",   32'(bus.pc_valid), 32'h0);
    step();
    check("run0_pc",      32'(bus.pc),       32'h00400000);
    check("run0_valid",   32'(bus.pc_valid), 32'h1);
    check("run0_adder_b", 32'(bus.adder_b),  32'h1);
    step();
    check("run1_pc",      32'(bus.pc),       32'h00400001);
    check("run1_adder_b", 32'(bus.adder_b),  32'h1);
    step();
    check("run2_pc",      32'(bus.pc),       32'h00400002);
    check("run2_adder_a", 32'(bus.adder_a),  32'h00400002);

    // Positive taken branch with request noise during the bubble
    jump_to(26'h0400020);
    check("jmp20_pc", 32'(bus.pc), 32'h00400020);
    branch_req   = 1'b1;
    branch_taken = 1'b1;
    br_imm       = 16'h4000;
    step();
    check("brp_busy",     32'(busy),         32'h1);
    check("brp_valid",    32'(bus.pc_valid), 32'h0);
    check("brp_adder_a",  32'(bus.adder_a),  32'h00400021);
    check("brp_adder_b",  32'(bus.adder_b),  32'h00004000);
    check("brp_pc_hold",  32'(bus.pc),       32'h00400020);
    br_imm   = 16'h1234;
    jump_req = 1'b1;
    #1;
    check("brp_imm_latched", 32'(bus.adder_b), 32'h00004000);
    step();
    check("brp_pc",    32'(bus.pc),       32'h00404021);
    check("brp_valid2",32'(bus.pc_valid), 32'h1);
    check("brp_busy2", 32'(busy),         32'h0);
    jump_req     = 1'b0;
    branch_req   = 1'b0;
    branch_taken = 1'b0;

    // Negative taken branch, then not-taken branch
    jump_to(26'h0400020);
    check("jmp20b_pc", 32'(bus.pc), 32'h00400020);
    branch_req   = 1'b1;
    branch_taken = 1'b1;
    br_imm       = 16'hFFE0;
    step();
    branch_req   = 1'b0;
    branch_taken = 1'b0;
    check("brn_adder_a", 32'(bus.adder_a), 32'h00400021);
    check("brn_adder_b", 32'(bus.adder_b), 32'h3FFFFFE0);
    step();
    check("brn_pc", 32'(bus.pc), 32'h00400001);
    jump_to(26'h0400020);
    branch_req   = 1'b1;
    branch_taken = 1'b0;
    step();
    branch_req = 1'b0;
    check("bnt_pc",    32'(bus.pc),       32'h00400021);
    check("bnt_valid", 32'(bus.pc_valid), 32'h1);
    check("bnt_busy",  32'(busy),         32'h0);

    // Jump beats simultaneous taken branch
    jump_to(26'h0400005);
    check("jmp5_pc", 32'(bus.pc), 32'h00400005);
    jump_req     = 1'b1;
    jump_target  = 26'h0000123;
    branch_req   = 1'b1;
    branch_taken = 1'b1;
    br_imm       = 16'h0010;
    step();
    jump_req     = 1'b0;
    branch_req   = 1'b0;
    branch_taken = 1'b0;
    check("jprio_pc",    32'(bus.pc),       32'h00000123);
    check("jprio_busy",  32'(busy),         32'h0);
    check("jprio_valid", 32'(bus.pc_valid), 32'h1);

    // Held by fetch_ready=0 then stall=1; requests during hold are dropped
    bus.fetch_ready = 1'b0;
    jump_req        = 1'b1;
    jump_target     = 26'h0000200;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        bus.fetch_ready = 1'b1;
        stall           = 1'b1;
      end
      step();
      check("hold_pc",    32'(bus.pc),       32'h00000123);
      check("hold_valid", 32'(bus.pc_valid), 32'h1);
    end
    stall    = 1'b0;
    jump_req = 1'b0;
    step();
    check("release_pc", 32'(bus.pc), 32'h00000124);

`ifdef PC_WRAP_DET_EN
    // Underflow past 0 into 3FFFFFFF, then sequential wrap to 0
    check("wrap_clear", 32'(pc_wrap), 32'h0);
    jump_to(26'h0000000);
    check("jmp0_pc", 32'(bus.pc), 32'h00000000);
    branch_req   = 1'b1;
    branch_taken = 1'b1;
    br_imm       = 16'hFFFE;
    step();
    branch_req   = 1'b0;
    branch_taken = 1'b0;
    check("wrap_pre", 32'(pc_wrap), 32'h0);
    step();
    check("under_pc",   32'(bus.pc), 32'h3FFFFFFF);
    check("under_wrap", 32'(pc_wrap), 32'h1);
    step();
    check("over_pc",   32'(bus.pc), 32'h00000000);
    check("over_wrap", 32'(pc_wrap), 32'h1);
`endif

    // Asynchronous reset in the branch bubble discards the pending update
    branch_req   = 1'b1;
    branch_taken = 1'b1;
    br_imm       = 16'h0005;
    step();
    branch_req   = 1'b0;
    branch_taken = 1'b0;
    check("rstbr_busy_pre", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstbr_pc",    32'(bus.pc),       32'h00400000);
    check("rstbr_busy",  32'(busy),         32'h0);
    check("rstbr_valid", 32'(bus.pc_valid), 32'h0);
`ifdef PC_WRAP_DET_EN
    check("rstbr_wrap",  32'(pc_wrap),      32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    check("reboot_valid", 32'(bus.pc_valid), 32'h0);
    step();
    check("reboot_pc0", 32'(bus.pc), 32'h00400000);
    step();
    check("reboot_pc1", 32'(bus.pc), 32'h00400001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Next-PC sequencer for the processor's 30-bit word-addressed program counter. Owns the PC register and drives one external shared 30-bit combinational adder (full_adder_30) through a small state machine. Serves three cases: sequential increment, PC-relative branch (two adder passes), and pseudo-direct jump. Sits between the control decoder and the instruction-fetch port; presents the PC with a valid/ready handshake.

Parameters:
PC_W, 30, PC width in words; the adder width.
IMM_W, 16, branch immediate width; sign-extended to PC_W.
JMP_W, 26, jump target field width.
RESET_PC, 30'h00400000, PC value loaded on reset.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
adder_a  output  PC_W  operand A to shared adder.
adder_b  output  PC_W  operand B to shared adder.
adder_sum  input  PC_W  combinational sum from shared adder (A+B mod 2^PC_W).
fetch_ready  input  1  fetch stage accepts current pc.
stall  input  1  pipeline stall; blocks consume.
branch_req  input  1  current instruction is a conditional branch.
branch_taken  input  1  branch condition true; qualified by branch_req.
br_imm  input  IMM_W  signed word offset, relative to pc+1.
jump_req  input  1  current instruction is a jump.
jump_target  input  JMP_W  jump target field.
pc  output  PC_W  current fetch address.
pc_valid  output  1  pc is valid for fetch.
busy  output  1  branch second pass in progress.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, pc_valid=0, busy=0, state=BOOT, npc=0. Reset mid-operation (including in BRANCH) aborts immediately; no pending update survives.
- States: BOOT, RUN, BRANCH.
- BOOT: one cycle after rst_n rises -> RUN; pc_valid=0; adder_a=pc, adder_b=1 (don't-care use).
- RUN: pc_valid=1. consume = pc_valid & fetch_ready & ~stall. Default adder_a=pc, adder_b=1 every RUN cycle.
- No consume: pc, state held; all requests ignored (not latched).
- Consume, priority jump_req > (branch_req & branch_taken) > sequential:
  - Jump: pc <= {adder_sum[PC_W-1:JMP_W], jump_target}; stay RUN; latency 1 cycle.
  - Branch taken: npc <= adder_sum (pc+1); state -> BRANCH; pc unchanged.
  - Sequential (incl. branch not taken): pc <= adder_sum; stay RUN.
- BRANCH: pc_valid=0, busy=1; adder_a=npc, adder_b=sign_extend(br_imm latched at consume); pc <= adder_sum; -> RUN. Taken branch costs exactly one bubble. All request inputs ignored in BRANCH.
- br_imm latched into an internal register on taken-branch consume; not re-sampled in BRANCH.
- Arithmetic: all sums mod 2^PC_W; 30'h3FFFFFFF+1 -> 30'h00000000, no flag (see optional feature). Negative offsets via sign extension, two's complement.
- Outputs registered except adder_a/adder_b, which are combinational from state/pc/npc/imm register.

Optional Feature:
Macro PC_WRAP_DET_EN. Defined: adds output port pc_wrap (1 bit), sticky, reset 0 by rst_n only; set when any pc update's true (PC_W+1)-bit sum overflows or a negative branch underflows past 0 (detected from operand signs vs sum MSB/carry). PC update itself unchanged. Undefined: port and logic absent; wrap silent.

Test Plan:
1. Reset, release, fetch_ready=1 for 3 cycles -> pc_valid 0 in BOOT, then pc = 00400000, 00400001, 00400002; adder_b=1 each RUN cycle.
2. At pc=00400020, branch_req=1, branch_taken=1, br_imm=16'h4000 -> next cycle busy=1, pc_valid=0, adder_a=00400021, adder_b=00004000; following cycle pc=00404021, pc_valid=1.
3. At pc=00400020, taken branch br_imm=16'hFFE0 -> adder_b=3FFFFFE0, final pc=00400001; branch_req=1, branch_taken=0 -> pc=00400021, no bubble.
4. At pc=00400005, jump_req=1 and branch taken both asserted, jump_target=26'h0000123 -> pc=00000123 next cycle, no bubble (jump wins).
5. fetch_ready=0 or stall=1 for 4 cycles with jump_req=1 -> pc held, pc_valid=1, no jump on release unless jump_req still high.
6. rst_n asserted during BRANCH -> pc=RESET_PC, busy=0, pc_valid=0 immediately; with PC_WRAP_DET_EN, pc=3FFFFFFF sequential consume -> pc=00000000, pc_wrap=1 until reset.
